// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular FIFO that presents the two oldest entries
// to dispatch and lets it consume zero, one or two of them per cycle, in order.
module inst_fetch_queue #(
  parameter int INS_PART_WID = 4,
  parameter int DEPTH        = 8,
  parameter int CNT_WID      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  input  logic [INS_PART_WID*4-1:0] wr_inst,
  output logic                      wr_ready,
  input  logic                      flush,
  output logic                      inst_1_valid,
  output logic [INS_PART_WID-1:0]   inst_type_1,
  output logic [INS_PART_WID-1:0]   inst_dest_1,
  output logic [INS_PART_WID-1:0]   inst_src0_1,
  output logic [INS_PART_WID-1:0]   inst_src1_1,
  input  logic                      inst_1_fetch,
  output logic                      inst_2_valid,
  output logic [INS_PART_WID-1:0]   inst_type_2,
  output logic [INS_PART_WID-1:0]   inst_dest_2,
  output logic [INS_PART_WID-1:0]   inst_src0_2,
  output logic [INS_PART_WID-1:0]   inst_src1_2,
  input  logic                      inst_2_fetch,
  output logic [CNT_WID-1:0]        count
);

  localparam int INST_WID = INS_PART_WID * 4;
  localparam int PTR_WID  = $clog2(DEPTH);
  localparam logic [CNT_WID-1:0] FULL_CNT = CNT_WID'(DEPTH);

  logic [INST_WID-1:0] mem [DEPTH];
  logic [PTR_WID-1:0]  rd_ptr;
  logic [PTR_WID-1:0]  wr_ptr;
  logic [PTR_WID-1:0]  rd_ptr_plus1;
  logic                push;
  logic                pop1;
  logic                pop2;
  logic [INST_WID-1:0] head_entry;
  logic [INST_WID-1:0] next_entry;

  assign wr_ready     = (count < FULL_CNT);
  assign inst_1_valid = (count != '0);
  assign inst_2_valid = (count >= CNT_WID'(2));

  assign push = wr_valid && wr_ready && !flush;
  assign pop1 = inst_1_fetch && inst_1_valid;
  assign pop2 = pop1 && inst_2_fetch && inst_2_valid;

  // DEPTH is a power of two, so the natural pointer overflow gives the modulo wrap.
  assign rd_ptr_plus1 = rd_ptr + PTR_WID'(1);
  assign head_entry   = mem[rd_ptr];
  assign next_entry   = mem[rd_ptr_plus1];

  // Storage is not reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WID'(1);
      end
      rd_ptr <= rd_ptr + PTR_WID'(pop1) + PTR_WID'(pop2);
      count  <= count + CNT_WID'(push) - CNT_WID'(pop1) - CNT_WID'(pop2);
    end
  end

  // Field outputs read as zero whenever their slot holds no live entry.
  always_comb begin
    inst_type_1 = '0;
    inst_dest_1 = '0;
    inst_src0_1 = '0;
    inst_src1_1 = '0;
    inst_type_2 = '0;
    inst_dest_2 = '0;
    inst_src0_2 = '0;
    inst_src1_2 = '0;
    if (inst_1_valid) begin
      {inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1} = head_entry;
    end
    if (inst_2_valid) begin
      {inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2} = next_entry;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, push/pop ordering, full/empty
// boundaries, wrap-around, flush priority and asynchronous reset.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_inst;
  logic        wr_ready;
  logic        flush;
  logic        inst_1_valid;
  logic [3:0]  inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1;
  logic        inst_1_fetch;
  logic        inst_2_valid;
  logic [3:0]  inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2;
  logic        inst_2_fetch;
  logic [3:0]  count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [$];

  inst_fetch_queue #(.INS_PART_WID(4), .DEPTH(8), .CNT_WID(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_inst      (wr_inst),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .inst_1_valid (inst_1_valid),
    .inst_type_1  (inst_type_1),
    .inst_dest_1  (inst_dest_1),
    .inst_src0_1  (inst_src0_1),
    .inst_src1_1  (inst_src1_1),
    .inst_1_fetch (inst_1_fetch),
    .inst_2_valid (inst_2_valid),
    .inst_type_2  (inst_type_2),
    .inst_dest_2  (inst_dest_2),
    .inst_src0_2  (inst_src0_2),
    .inst_src1_2  (inst_src1_2),
    .inst_2_fetch (inst_2_fetch),
    .count        (count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] head1();
    return {inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1};
  endfunction

  function automatic logic [15:0] head2();
    return {inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic f1,
                       input logic f2, input logic fl);
    wr_valid     = v;
    wr_inst      = d;
    inst_1_fetch = f1;
    inst_2_fetch = f2;
    flush        = fl;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_v1"}, 32'(inst_1_valid), 32'd0);
    check({tag, "_v2"}, 32'(inst_2_valid), 32'd0);
    check({tag, "_f1"}, 32'(head1()), 32'd0);
    check({tag, "_f2"}, 32'(head2()), 32'd0);
    check({tag, "_rdy"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check_empty("reset_hold");
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    // Single push, visible one cycle later
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    #1;
    check("push_nobypass_v1", 32'(inst_1_valid), 32'd0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("push1_v1", 32'(inst_1_valid), 32'd1);
    check("push1_type", 32'(inst_type_1), 32'd1);
    check("push1_dest", 32'(inst_dest_1), 32'd2);
    check("push1_src0", 32'(inst_src0_1), 32'd3);
    check("push1_src1", 32'(inst_src1_1), 32'd4);
    check("push1_v2", 32'(inst_2_valid), 32'd0);
    check("push1_f2zero", 32'(head2()), 32'd0);
    check("push1_count", 32'(count), 32'd1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    check("pop1_count", 32'(count), 32'd0);

    // Fill to full, then a dropped ninth push
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {4{4'(i)}}, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("full_count", 32'(count), 32'd8);
    check("full_rdy", 32'(wr_ready), 32'd0);
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    tick();
    check("drop9_count", 32'(count), 32'd8);
    check("drop9_head1", 32'(head1()), 32'h0000);
    check("drop9_head2", 32'(head2()), 32'h1111);

    // Dual drain; a pending pop must not raise wr_ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      #1;
      if (i == 0) check("full_pop_rdy", 32'(wr_ready), 32'd0);
      check($sformatf("drain_h1_%0d", i), 32'(head1()), 32'({4{4'(2*i)}}));
      check($sformatf("drain_h2_%0d", i), 32'(head2()), 32'({4{4'(2*i+1)}}));
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("drain_count", 32'(count), 32'd0);

    // Dual fetch with only one entry pops exactly one
    drive(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    check("one_dual_count", 32'(count), 32'd0);
    check("one_dual_v1", 32'(inst_1_valid), 32'd0);

    // inst_2_fetch alone is ignored
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, {8'h00, 4'(i), 4'(i)}, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    check("f2only_count", 32'(count), 32'd3);
    check("f2only_head", 32'(head1()), 32'h0011);

    // Flush beats simultaneous push and fetch
    drive(1'b1, 16'h0044, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    tick();
    check("preflush_count", 32'(count), 32'd5);
    drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_empty("flush");

    // Wrap-around: fill to 6, then push with in-order fetch for 10 cycles
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
      model.push_back(16'h1000 + 16'(i));
      tick();
    end
    check("wrap_fill_count", 32'(count), 32'd6);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 16'h2000 + 16'(k), 1'b1, (k == 0), 1'b0);
      #1;
      check($sformatf("wrap_h1_%0d", k), 32'(head1()), 32'(model[0]));
      if (k == 0) check("wrap_h2_0", 32'(head2()), 32'(model[1]));
      void'(model.pop_front());
      if (k == 0) void'(model.pop_front());
      model.push_back(16'h2000 + 16'(k));
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("wrap_count", 32'(count), 32'd5);
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      #1;
      check($sformatf("wrap_tail_%0d", j), 32'(head1()), 32'h2005 + 32'(j));
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("wrap_empty", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("prerst_count", 32'(count), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check_empty("async_rst");
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0E0E, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("postrst_count", 32'(count), 32'd1);
    check("postrst_head", 32'(head1()), 32'h0E0E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
